keypad_scan: RTL



---
 rtl/keypad_scan.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/keypad_scan.sv
// 4x4 active-low matrix keypad scanner: walks one low column at a time, classifies each
// full four-column scan, and debounces presses and releases over whole scans.
module keypad_scan #(
   parameter int unsigned SCAN_MAX_COUNT = 31_249,
   parameter int unsigned DEBOUNCE_SCANS = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   localparam int unsigned CNT_W = $clog2(SCAN_MAX_COUNT + 1);
   localparam int unsigned DB_W  = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(SCAN_MAX_COUNT);
   localparam logic [DB_W-1:0]  DB_TERM  = DB_W'(DEBOUNCE_SCANS);
   localparam logic [DB_W-1:0]  DB_ONE   = DB_W'(1);

   typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} state_e;

   function automatic logic [3:0] key_lookup(input logic [1:0] r, input logic [1:0] c);
      logic [3:0] k;
      case ({r, c})
         4'd0:    k = 4'h1;
         4'd1:    k = 4'h2;
         4'd2:    k = 4'h3;
         4'd3:    k = 4'hA;
         4'd4:    k = 4'h4;
         4'd5:    k = 4'h5;
         4'd6:    k = 4'h6;
         4'd7:    k = 4'hB;
         4'd8:    k = 4'h7;
         4'd9:    k = 4'h8;
         4'd10:   k = 4'h9;
         4'd11:   k = 4'hC;
         4'd12:   k = 4'hE;
         4'd13:   k = 4'h0;
         4'd14:   k = 4'hF;
         default: k = 4'hD;
      endcase
      return k;
   endfunction

   logic [3:0]       row_meta_q, row_sync_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       col_idx_q, col_idx_d;
   logic [3:0]       col_q, col_d;
   logic [1:0]       hits_q, hits_d;
   logic [1:0]       hit_row_q, hit_row_d, hit_col_q, hit_col_d;
   state_e           state_q, state_d;
   logic [3:0]       cand_q, cand_d, code_q, code_d;
   logic [DB_W-1:0]  db_q, db_d;
   logic             valid_q, valid_d;

   logic             tick, scan_end;
   logic [3:0]       pressed;
   logic [2:0]       row_hits, hit_sum;
   logic [1:0]       sample_row;
   logic             scan_one;
   logic [3:0]       scan_key;

   assign tick     = (cnt_q == CNT_TERM);
   assign scan_end = tick && (col_idx_q == 2'd3);
   assign pressed  = ~row_sync_q;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      row_hits   = 3'd0;
      sample_row = 2'd0;
      for (int r = 0; r < 4; r++) begin
         if (pressed[r]) begin
            row_hits   = row_hits + 3'd1;
            sample_row = 2'(r);
         end
      end
   end

   // Per-scan totals restart at column 0 and saturate at 2: anything above one key is ghosting.
   always_comb begin
      cnt_d     = tick ? '0 : cnt_q + 1'b1;
      col_idx_d = tick ? col_idx_q + 2'd1 : col_idx_q;
      col_d     = tick ? {col_q[0], col_q[3:1]} : col_q;
      hit_sum   = ((col_idx_q == 2'd0) ? 3'd0 : {1'b0, hits_q}) + row_hits;
      hits_d    = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
      hit_row_d = (row_hits == 3'd1) ? sample_row : hit_row_q;
      hit_col_d = (row_hits == 3'd1) ? col_idx_q : hit_col_q;
      scan_one  = (hits_d == 2'd1);
      scan_key  = key_lookup(hit_row_d, hit_col_d);
   end

   always_comb begin
      state_d = state_q;
      cand_d  = cand_q;
      code_d  = code_q;
      db_d    = db_q;
      valid_d = 1'b0;
      if (scan_end) begin
         case (state_q)
            IDLE: begin
               if (scan_one) begin
                  state_d = PRESS_DB;
                  cand_d  = scan_key;
                  db_d    = DB_ONE;
               end
            end
            PRESS_DB: begin
               if (!scan_one) begin
                  state_d = IDLE;
               end else if (scan_key != cand_q) begin
                  cand_d = scan_key;
                  db_d   = DB_ONE;
               end else if (db_q + 1'b1 == DB_TERM) begin
                  state_d = HELD;
                  code_d  = cand_q;
                  valid_d = 1'b1;
               end else begin
                  db_d = db_q + 1'b1;
               end
            end
            HELD: begin
               if (!(scan_one && scan_key == code_q)) begin
                  state_d = RELEASE_DB;
                  db_d    = DB_ONE;
               end
            end
            RELEASE_DB: begin
               if (scan_one && scan_key == code_q) begin
                  state_d = HELD;
               end else if (db_q + 1'b1 == DB_TERM) begin
                  state_d = IDLE;
               end else begin
                  db_d = db_q + 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk) begin
      if (reset) begin
         row_meta_q <= 4'hF;
         row_sync_q <= 4'hF;
         cnt_q      <= '0;
         col_idx_q  <= 2'd0;
         col_q      <= 4'b0111;
         hits_q     <= 2'd0;
         hit_row_q  <= 2'd0;
         hit_col_q  <= 2'd0;
         state_q    <= IDLE;
         cand_q     <= 4'h0;
         code_q     <= 4'h0;
         db_q       <= '0;
         valid_q    <= 1'b0;
      end else begin
         row_meta_q <= row;
         row_sync_q <= row_meta_q;
         cnt_q      <= cnt_d;
         col_idx_q  <= col_idx_d;
         col_q      <= col_d;
         if (tick) begin
            hits_q    <= hits_d;
            hit_row_q <= hit_row_d;
            hit_col_q <= hit_col_d;
         end
         state_q    <= state_d;
         cand_q     <= cand_d;
         code_q     <= code_d;
         db_q       <= db_d;
         valid_q    <= valid_d;
      end
   end

   assign col       = col_q;
   assign key_code  = code_q;
   assign key_valid = valid_q;
   assign key_held  = (state_q == HELD) || (state_q == RELEASE_DB);

endmodule
